// File: rtl/wide_add_pkg.sv
// rtl/wide_add_pkg.sv - shared types and constants for the wide add sequencer
package wide_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SLICE_W = 16;

  // A single-slice operand still needs a 1-bit counter.
  function automatic int cnt_width(input int width);
    int n;
    n = width / SLICE_W;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wide_add_sequencer_if.sv
// rtl/wide_add_sequencer_if.sv - request, shared-adder and result signals of the sequencer
// req_sub_i exists only when WIDE_ADD_SUB_EN is defined.
interface wide_add_sequencer_if #(
  parameter int WIDTH = 64
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic [WIDTH-1:0] req_a_i;
  logic [WIDTH-1:0] req_b_i;
  logic             req_carry_i;
`ifdef WIDE_ADD_SUB_EN
  logic             req_sub_i;
`endif
  logic [15:0]      add_a_o;
  logic [15:0]      add_b_o;
  logic             add_carry_o;
  logic [15:0]      add_sum_i;
  logic             add_carry_i;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [WIDTH-1:0] res_sum_o;
  logic             res_carry_o;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, req_carry_i,
`ifdef WIDE_ADD_SUB_EN
    input  req_sub_i,
`endif
    input  add_sum_i, add_carry_i, res_ready_i,
    output req_ready_o, add_a_o, add_b_o, add_carry_o,
    output res_valid_o, res_sum_o, res_carry_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, req_carry_i,
`ifdef WIDE_ADD_SUB_EN
    output req_sub_i,
`endif
    output add_sum_i, add_carry_i, res_ready_i,
    input  req_ready_o, add_a_o, add_b_o, add_carry_o,
    input  res_valid_o, res_sum_o, res_carry_o
  );

endinterface

// File: rtl/wide_add_sequencer_slice_shift_reg.sv
// rtl/wide_add_sequencer_slice_shift_reg.sv - WIDTH-bit register with parallel load and 16-bit right shift
// Only the low OUT_W bits are exported so operand registers expose just the current slice.
module slice_shift_reg
  import wide_add_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int OUT_W = WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [WIDTH-1:0]   load_data_i,
  input  logic               shift_i,
  input  logic [SLICE_W-1:0] insert_i,
  output logic [OUT_W-1:0]   data_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] shifted;

  generate
    if (WIDTH == SLICE_W) begin : g_single
      assign shifted = insert_i;
    end else begin : g_multi
      assign shifted = {insert_i, data_q[WIDTH-1:SLICE_W]};
    end
  endgenerate

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = load_data_i;
    end else if (shift_i) begin
      data_d = shifted;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q[OUT_W-1:0];

endmodule

// File: rtl/wide_add_sequencer.sv
// rtl/wide_add_sequencer.sv - adds WIDTH-bit operands one 16-bit slice per cycle on a shared adder
// Subtraction (A + ~B + 1) is available when WIDE_ADD_SUB_EN is defined.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  wide_add_sequencer_if.slave   bus
);

  localparam int N  = WIDTH / SLICE_W;
  localparam int CW = cnt_width(WIDTH);

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic                 carry_q;
  logic                 ready_q;
  logic                 valid_q;
  logic                 accept;
  logic                 run;
  logic [WIDTH-1:0]     b_load;
  logic                 carry_load;
  logic [SLICE_W-1:0]   a_slice;
  logic [SLICE_W-1:0]   b_slice;
  logic [WIDTH-1:0]     sum_q;

  assign accept = ready_q & bus.req_valid_i;
  assign run    = (state_q == RUN);

`ifdef WIDE_ADD_SUB_EN
  assign b_load     = bus.req_sub_i ? ~bus.req_b_i : bus.req_b_i;
  assign carry_load = bus.req_sub_i ? 1'b1 : bus.req_carry_i;
`else
  assign b_load     = bus.req_b_i;
  assign carry_load = bus.req_carry_i;
`endif

  slice_shift_reg #(.WIDTH(WIDTH), .OUT_W(SLICE_W)) u_a_reg (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (accept),
    .load_data_i (bus.req_a_i),
    .shift_i     (run),
    .insert_i    ('0),
    .data_o      (a_slice)
  );

  slice_shift_reg #(.WIDTH(WIDTH), .OUT_W(SLICE_W)) u_b_reg (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (accept),
    .load_data_i (b_load),
    .shift_i     (run),
    .insert_i    ('0),
    .data_o      (b_slice)
  );

  // Each slice result enters at the top, so after N shifts slice 0 sits at the bottom.
  slice_shift_reg #(.WIDTH(WIDTH), .OUT_W(WIDTH)) u_sum_reg (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (accept),
    .load_data_i ('0),
    .shift_i     (run),
    .insert_i    (bus.add_sum_i),
    .data_o      (sum_q)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
            carry_q <= carry_load;
            ready_q <= 1'b0;
          end
        end
        RUN: begin
          carry_q <= bus.add_carry_i;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready_o = ready_q;
  assign bus.res_valid_o = valid_q;
  assign bus.res_sum_o   = sum_q;
  assign bus.res_carry_o = carry_q;
  assign bus.add_a_o     = run ? a_slice : '0;
  assign bus.add_b_o     = run ? b_slice : '0;
  assign bus.add_carry_o = run & carry_q;

endmodule
